// File: rtl/rt_timestamp_pkg.sv
// rt_timestamp_pkg: register map constants, FSM states and address decode for the real-time timestamp block
package rt_timestamp_pkg;
   localparam logic [3:0] ADDR_MAIN    = 4'h0;
   localparam logic [3:0] REG_PROMSTAT = 4'h8;
   localparam logic [3:0] REG_PROMRES  = 4'h9;
   localparam logic [3:0] REG_IPADDR   = 4'hA;
   localparam logic [3:0] REG_ETHSTAT  = 4'hB;
   localparam logic [3:0] REG_TSMIN_DEF = 4'hC;
   localparam logic [3:0] REG_TSMAX_DEF = 4'hD;
   localparam logic [3:0] REG_TSNUM_DEF = 4'hE;
   typedef enum logic {WAIT_FIRST, RUN} ts_state_t;
   function automatic logic hits_reg(input logic [15:0] addr, input logic [3:0] off);
      return addr[15:12] == ADDR_MAIN && addr[7:4] == 4'h0 && addr[3:0] == off;
   endfunction
endpackage

// File: rtl/rt_period_stats.sv
// rt_period_stats: running min/max of measured periods and a wrapping 16-bit sample count
module rt_period_stats #(
   parameter int CNT_W = 32
) (
   input  logic             sysclk,
   input  logic             reset_n,
   input  logic [CNT_W-1:0] sample,
   input  logic             sample_en,
   input  logic             clear,
   output logic [CNT_W-1:0] min,
   output logic [CNT_W-1:0] max,
   output logic [15:0]      num
);
   always_ff @(posedge sysclk or negedge reset_n)
      if (!reset_n) begin
         min <= '1;
         max <= '0;
         num <= '0;
      end else if (clear) begin
         min <= '1;
         max <= '0;
         num <= '0;
      end else if (sample_en) begin
         if (sample < min) min <= sample;
         if (sample > max) max <= sample;
         num <= num + 16'd1;
      end
endmodule

// File: rtl/rt_timestamp.sv
// rt_timestamp: measures sysclk ticks between real-time block read requests and exposes period statistics
module rt_timestamp
   import rt_timestamp_pkg::*;
#(
   parameter int         CNT_W     = 32,
   parameter logic [3:0] REG_TSMIN = REG_TSMIN_DEF,
   parameter logic [3:0] REG_TSMAX = REG_TSMAX_DEF,
   parameter logic [3:0] REG_TSNUM = REG_TSNUM_DEF
) (
   input  logic             sysclk,
   input  logic             reset_n,
   input  logic             req_blk_rt_rd,
   input  logic [15:0]      reg_raddr,
   input  logic [15:0]      reg_waddr,
   input  logic             reg_wen,
   output logic [CNT_W-1:0] timestamp,
   output logic [31:0]      reg_rdata,
   output logic             ts_valid
);
   ts_state_t state;
   logic [CNT_W-1:0] cnt, st_min, st_max;
   logic [15:0] st_num;
   logic req_q, armed, req_edge, clear;
   // armed stays low until the request is seen low, so a level held across reset release is not an edge
   assign req_edge = req_blk_rt_rd & ~req_q & armed;
   assign clear = reg_wen & hits_reg(reg_waddr, REG_TSNUM);
   always_ff @(posedge sysclk or negedge reset_n)
      if (!reset_n) begin
         state     <= WAIT_FIRST;
         cnt       <= '0;
         timestamp <= '0;
         ts_valid  <= 1'b0;
         req_q     <= 1'b0;
         armed     <= 1'b0;
      end else begin
         req_q <= req_blk_rt_rd;
         armed <= armed | ~req_blk_rt_rd;
         if (state == WAIT_FIRST) begin
            if (req_edge) begin
               state <= RUN;
               cnt   <= CNT_W'(1);
            end
         end else if (req_edge) begin
            timestamp <= cnt;
            ts_valid  <= 1'b1;
            cnt       <= CNT_W'(1);
         end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   rt_period_stats #(.CNT_W(CNT_W)) u_stats (
      .sysclk   (sysclk),
      .reset_n  (reset_n),
      .sample   (cnt),
      .sample_en(req_edge && state == RUN),
      .clear    (clear),
      .min      (st_min),
      .max      (st_max),
      .num      (st_num)
   );
   always_comb
      reg_rdata = hits_reg(reg_raddr, REG_TSMIN) ? 32'(st_min) :
                  hits_reg(reg_raddr, REG_TSMAX) ? 32'(st_max) :
                  hits_reg(reg_raddr, REG_TSNUM) ? {15'd0, ts_valid, st_num} : 32'd0;
endmodule
